// File: rtl/seq_det_scheduler_if.sv
// Request/result bundle between the requesters and the shared serial
// pattern detector. The requesters drive req/data; the scheduler returns
// the per-word result and its debug/status signals.
interface seq_det_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WORD_W + 1);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] data;
    logic [NREQ-1:0]        ack;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [CW-1:0]          match_cnt;
    logic                   busy;
    logic                   ser_bit;

    modport master (
        output req, data,
        input  ack, done, done_id, match_cnt, busy, ser_bit
    );

    modport slave (
        input  req, data,
        output ack, done, done_id, match_cnt, busy, ser_bit
    );
endinterface

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that owns a single bit-serial overlapping pattern
// detector. A granted word is shifted MSB-first, one bit per clock, and the
// hit count is returned to its requester with a one-cycle ack/done pulse.
module seq_det_scheduler #(
    parameter int             NREQ   = 4,
    parameter int             WORD_W = 8,
    parameter int             PAT_W  = 3,
    parameter logic [PAT_W-1:0] PAT  = 3'b101
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_scheduler_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr, rr_nxt;
    logic [IDW-1:0]    grant_id, grant_nxt;
    logic [WORD_W-1:0] sr, sr_nxt;
    logic [CW-1:0]     bit_cnt, cnt_nxt;
    logic [PAT_W-1:0]  hist, hist_nxt;
    logic [CW-1:0]     hit_cnt, hits_nxt;
    logic [NREQ-1:0]   ack_q, ack_nxt;
    logic              done_q, done_nxt;
    logic [IDW-1:0]    done_id_q, done_id_nxt;
    logic [CW-1:0]     match_q, match_nxt;

    logic              found;
    logic [IDW-1:0]    pick;
    logic [PAT_W-1:0]  hist_shift;
    logic [CW-1:0]     cnt_inc;
    logic              hit_now;

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    // Next-state, datapath and registered-output decode for the scheduler.
    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr_ptr;
        grant_nxt   = grant_id;
        sr_nxt      = sr;
        cnt_nxt     = bit_cnt;
        hist_nxt    = hist;
        hits_nxt    = hit_cnt;
        ack_nxt     = '0;
        done_nxt    = 1'b0;
        done_id_nxt = done_id_q;
        match_nxt   = match_q;

        hist_shift = {hist[PAT_W-2:0], sr[WORD_W-1]};
        cnt_inc    = bit_cnt + CW'(1);
        hit_now    = (hist_shift == PAT) && (cnt_inc >= CW'(PAT_W));

        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    sr_nxt    = bus.data[int'(pick)*WORD_W +: WORD_W];
                    cnt_nxt   = '0;
                    hist_nxt  = '0;
                    hits_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt   = {sr[WORD_W-2:0], 1'b0};
                hist_nxt = hist_shift;
                cnt_nxt  = cnt_inc;
                hits_nxt = hit_cnt + CW'(hit_now);
                if (bit_cnt == CW'(WORD_W - 1)) begin
                    state_nxt         = DONE;
                    done_nxt          = 1'b1;
                    ack_nxt[grant_id] = 1'b1;
                    done_id_nxt       = grant_id;
                    match_nxt         = hits_nxt;
                    rr_nxt            = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; a synchronous reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            hist      <= '0;
            hit_cnt   <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            match_q   <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_id  <= grant_nxt;
            sr        <= sr_nxt;
            bit_cnt   <= cnt_nxt;
            hist      <= hist_nxt;
            hit_cnt   <= hits_nxt;
            ack_q     <= ack_nxt;
            done_q    <= done_nxt;
            done_id_q <= done_id_nxt;
            match_q   <= match_nxt;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = match_q;
    assign bus.busy      = (state == SHIFT) || (state == DONE);
    assign bus.ser_bit   = (state == SHIFT) ? sr[WORD_W-1] : 1'b0;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: reset state, single-word detection,
// history clearing, round-robin order and spacing, pointer wrap, mid-word
// reset and a request that is dropped right after grant.
module tb_seq_det_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   cyc;

    seq_det_scheduler_if #(.NREQ(4), .WORD_W(8)) bus ();

    seq_det_scheduler #(
        .NREQ(4), .WORD_W(8), .PAT_W(3), .PAT(3'b101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute cycle counter used to measure done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            step();
            cycles++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
        checks++; if (bus.ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); else passes++;
        checks++; if (bus.match_cnt !== 4'd0) $display("[TB] FAIL reset_match: got %0d expected 0", bus.match_cnt); else passes++;
        checks++; if (bus.ser_bit !== 1'b0) $display("[TB] FAIL reset_ser_bit: got %b expected 0", bus.ser_bit); else passes++;
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        int busy_cycles;
        w = 8'b1010_1010;
        bus.data[7:0] = w;
        bus.req = 4'b0001;
        step();
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            checks++; if (bus.ser_bit !== w[7-i]) $display("[TB] FAIL single_ser_bit%0d: got %b expected %b", i, bus.ser_bit, w[7-i]); else passes++;
            checks++; if (bus.done !== 1'b0) $display("[TB] FAIL single_early_done%0d: got %b expected 0", i, bus.done); else passes++;
            step();
        end
        if (bus.busy === 1'b1) busy_cycles++;
        checks++; if (bus.done !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", bus.done); else passes++;
        checks++; if (bus.ack !== 4'b0001) $display("[TB] FAIL single_ack: got %b expected 0001", bus.ack); else passes++;
        checks++; if (bus.done_id !== 2'd0) $display("[TB] FAIL single_done_id: got %0d expected 0", bus.done_id); else passes++;
        checks++; if (bus.match_cnt !== 4'd3) $display("[TB] FAIL single_match: got %0d expected 3", bus.match_cnt); else passes++;
        checks++; if (bus.ser_bit !== 1'b0) $display("[TB] FAIL single_ser_idle: got %b expected 0", bus.ser_bit); else passes++;
        bus.req = 4'b0000;
        step();
        checks++; if (busy_cycles !== 9) $display("[TB] FAIL single_busy_len: got %0d expected 9", busy_cycles); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_busy_after: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0 || bus.ack !== 4'b0000) $display("[TB] FAIL single_pulse_width: got done=%b ack=%b expected 0/0000", bus.done, bus.ack); else passes++;
        checks++; if (bus.match_cnt !== 4'd3) $display("[TB] FAIL single_match_hold: got %0d expected 3", bus.match_cnt); else passes++;
    endtask

    task automatic test_clear_history();
        bit seen;
        int cycles;
        bus.data[15:8] = 8'hFF;
        bus.req = 4'b0010;
        wait_done(seen, cycles);
        bus.req = 4'b0000;
        checks++; if (!seen) $display("[TB] FAIL ff_timeout: got no done expected done"); else passes++;
        checks++; if (bus.done_id !== 2'd1) $display("[TB] FAIL ff_done_id: got %0d expected 1", bus.done_id); else passes++;
        checks++; if (bus.match_cnt !== 4'd0) $display("[TB] FAIL ff_match: got %0d expected 0", bus.match_cnt); else passes++;
        step();
        bus.data[15:8] = 8'b0000_0101;
        bus.req = 4'b0010;
        wait_done(seen, cycles);
        bus.req = 4'b0000;
        checks++; if (!seen) $display("[TB] FAIL tail_timeout: got no done expected done"); else passes++;
        checks++; if (bus.ack !== 4'b0010) $display("[TB] FAIL tail_ack: got %b expected 0010", bus.ack); else passes++;
        checks++; if (bus.match_cnt !== 4'd1) $display("[TB] FAIL tail_match: got %0d expected 1", bus.match_cnt); else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int cycles;
        int last_done;
        logic [3:0] exp_match [4];
        exp_match[0] = 4'd3;
        exp_match[1] = 4'd0;
        exp_match[2] = 4'd1;
        exp_match[3] = 4'd2;
        do_reset();
        bus.data = {8'b0101_1010, 8'b0000_0101, 8'hFF, 8'b1010_1010};
        bus.req = 4'b1111;
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(seen, cycles);
            checks++; if (!seen) $display("[TB] FAIL rr_timeout%0d: got no done expected done", k); else passes++;
            checks++; if (bus.ack !== (4'b0001 << k)) $display("[TB] FAIL rr_ack%0d: got %b expected %b", k, bus.ack, 4'b0001 << k); else passes++;
            checks++; if (int'(bus.done_id) !== k) $display("[TB] FAIL rr_done_id%0d: got %0d expected %0d", k, bus.done_id, k); else passes++;
            checks++; if (bus.match_cnt !== exp_match[k]) $display("[TB] FAIL rr_match%0d: got %0d expected %0d", k, bus.match_cnt, exp_match[k]); else passes++;
            if (k > 0) begin
                checks++; if (cyc - last_done !== 10) $display("[TB] FAIL rr_spacing%0d: got %0d expected 10", k, cyc - last_done); else passes++;
            end
            last_done = cyc;
            bus.req[k] = 1'b0;
        end
        step();
    endtask

    task automatic test_rr_pointer();
        bit seen;
        int cycles;
        bus.data[15:0] = {8'hFF, 8'b1010_1010};
        bus.req = 4'b0010;
        wait_done(seen, cycles);
        bus.req = 4'b0000;
        checks++; if (!seen || bus.done_id !== 2'd1) $display("[TB] FAIL ptr_setup: got seen=%b id=%0d expected 1/1", seen, bus.done_id); else passes++;
        step();
        bus.req = 4'b0011;
        wait_done(seen, cycles);
        bus.req[0] = 1'b0;
        checks++; if (!seen || bus.done_id !== 2'd0) $display("[TB] FAIL ptr_first: got seen=%b id=%0d expected 1/0", seen, bus.done_id); else passes++;
        wait_done(seen, cycles);
        bus.req[1] = 1'b0;
        checks++; if (!seen || bus.done_id !== 2'd1) $display("[TB] FAIL ptr_second: got seen=%b id=%0d expected 1/1", seen, bus.done_id); else passes++;
        step();
    endtask

    task automatic test_reset_mid_word();
        bit seen;
        int cycles;
        bus.data[7:0] = 8'b1011_0101;
        bus.req = 4'b0001;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.ack !== 4'b0000 || bus.done !== 1'b0) $display("[TB] FAIL midrst_ack: got ack=%b done=%b expected 0000/0", bus.ack, bus.done); else passes++;
        checks++; if (bus.ser_bit !== 1'b0) $display("[TB] FAIL midrst_ser_bit: got %b expected 0", bus.ser_bit); else passes++;
        wait_done(seen, cycles);
        bus.req = 4'b0000;
        checks++; if (!seen || cycles !== 9) $display("[TB] FAIL midrst_latency: got seen=%b cycles=%0d expected 1/9", seen, cycles); else passes++;
        checks++; if (bus.match_cnt !== 4'd3) $display("[TB] FAIL midrst_match: got %0d expected 3", bus.match_cnt); else passes++;
        checks++; if (bus.ack !== 4'b0001) $display("[TB] FAIL midrst_final_ack: got %b expected 0001", bus.ack); else passes++;
        step();
    endtask

    task automatic test_pulsed_request();
        bit seen;
        int cycles;
        bus.data[7:0] = 8'b1010_1010;
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        bus.data[7:0] = 8'h00;
        wait_done(seen, cycles);
        checks++; if (!seen || cycles !== 8) $display("[TB] FAIL pulse_latency: got seen=%b cycles=%0d expected 1/8", seen, cycles); else passes++;
        checks++; if (bus.ack !== 4'b0001) $display("[TB] FAIL pulse_ack: got %b expected 0001", bus.ack); else passes++;
        checks++; if (bus.match_cnt !== 4'd3) $display("[TB] FAIL pulse_match: got %0d expected 3", bus.match_cnt); else passes++;
        step();
        step();
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL pulse_no_regrant: got busy=%b expected 0", bus.busy); else passes++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        passes   = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        test_reset();
        test_single_word();
        test_clear_history();
        test_back_to_back();
        test_rr_pointer();
        test_reset_mid_word();
        test_pulsed_request();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
